// File: rtl/lightsaber_pkg.sv
// Shared definitions for the lightsaber blade driver.
//   - blade mode codes as they arrive from the configuration register
//   - blade FSM state encoding
//   - flicker LFSR seed and tap mask (used only when BLADE_FLICKER_EN is defined)
package lightsaber_pkg;

  localparam logic [1:0] MODE_OFF      = 2'b00;
  localparam logic [1:0] MODE_SOLID    = 2'b01;
  localparam logic [1:0] MODE_PULSE    = 2'b10;
  localparam logic [1:0] MODE_UNSTABLE = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF     = 2'b00,
    ST_EXTEND  = 2'b01,
    ST_ON      = 2'b10,
    ST_RETRACT = 2'b11
  } blade_state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback = q[7]^q[5]^q[4]^q[3]
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/blade_pwm.sv
// Blade brightness PWM.
//   clk, rst_n : clock, async active-low reset
//   mode_i     : registered blade mode (selects the level pattern)
//   lit_i      : at least one segment will be lit after this edge
//   pwm_out_o  : registered PWM output
// Optional feature macro: BLADE_FLICKER_EN (LFSR flicker in mode 11;
// without it mode 11 runs at full level like solid).
module blade_pwm
  import lightsaber_pkg::*;
#(
  parameter int PWM_BITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_i,
  input  logic       lit_i,
  output logic       pwm_out_o
);

  localparam logic [PWM_BITS:0] LVL_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS:0] LVL_HALF = {2'b01, {(PWM_BITS-1){1'b0}}};

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS:0]   pulse_q, pulse_d;
  logic                pulse_up_q, pulse_up_d;
  logic [PWM_BITS:0]   level_d;
  logic                pwm_q;
  logic                wrap;

  assign wrap  = &cnt_q;
  assign cnt_d = cnt_q + 1'b1;

  // Triangle: one step per PWM period, turning around at either end.
  always_comb begin
    pulse_d    = pulse_q;
    pulse_up_d = pulse_up_q;
    if (wrap && mode_i == MODE_PULSE) begin
      if (pulse_up_q) begin
        if (pulse_q == LVL_FULL) begin
          pulse_up_d = 1'b0;
          pulse_d    = pulse_q - 1'b1;
        end else begin
          pulse_d    = pulse_q + 1'b1;
        end
      end else begin
        if (pulse_q == LVL_HALF) begin
          pulse_up_d = 1'b1;
          pulse_d    = pulse_q + 1'b1;
        end else begin
          pulse_d    = pulse_q - 1'b1;
        end
      end
    end
  end

`ifdef BLADE_FLICKER_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (wrap && mode_i == MODE_UNSTABLE)
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

  // Level is taken from the post-edge register values so the registered
  // output lines up with the counter value it is compared against.
  always_comb begin
    level_d = LVL_FULL;
    case (mode_i)
      MODE_PULSE:    level_d = pulse_d;
`ifdef BLADE_FLICKER_EN
      MODE_UNSTABLE: level_d = LVL_HALF + (PWM_BITS+1)'(lfsr_d[PWM_BITS-2:0]);
`else
      MODE_UNSTABLE: level_d = LVL_FULL;
`endif
      default:       level_d = LVL_FULL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      pulse_q    <= LVL_HALF;
      pulse_up_q <= 1'b1;
      pwm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      pulse_up_q <= pulse_up_d;
      pwm_q      <= lit_i && ({1'b0, cnt_d} < level_d);
    end
  end

  assign pwm_out_o = pwm_q;

endmodule

// File: rtl/lightsaber_blade_driver.sv
// Lightsaber blade driver: consumes the 2-bit blade mode from the config
// register, extends/retracts the blade one segment at a time and drives the
// shared brightness PWM.
//   clk, rst_n : clock, async active-low reset
//   cfg        : blade mode (00 off, 01 solid, 10 pulse, 11 unstable)
//   seg_en     : thermometer segment enables, bit 0 at the hilt
//   pwm_out    : brightness PWM for all lit segments
//   busy       : extending or retracting
//   blade_on   : fully extended
// Optional feature macro: BLADE_FLICKER_EN (passed through to blade_pwm).
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_OFF     | blade dark, seg_count = 0
// ST_EXTEND  | lighting one more segment every STEP_DIV cycles
// ST_ON      | all segments lit, brightness follows mode
// ST_RETRACT | darkening one segment every STEP_DIV cycles
module lightsaber_blade_driver
  import lightsaber_pkg::*;
#(
  parameter int SEGMENTS = 8,
  parameter int STEP_DIV = 4,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          cfg,
  output logic [SEGMENTS-1:0] seg_en,
  output logic                pwm_out,
  output logic                busy,
  output logic                blade_on
);

  localparam int SEG_W = $clog2(SEGMENTS + 1);
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  blade_state_e     state_q, state_d;
  logic [1:0]       cfg_q;
  logic [SEG_W-1:0] seg_count_q, seg_count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step;
  logic             lit_d;

  assign step = (div_q == DIV_W'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cfg_q       <= MODE_OFF;
      seg_count_q <= '0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg;
      seg_count_q <= seg_count_d;
      div_q       <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:
        if (cfg_q != MODE_OFF) state_d = ST_EXTEND;
      ST_EXTEND:
        if (cfg_q == MODE_OFF)
          state_d = ST_RETRACT;
        else if (step && seg_count_q == SEG_W'(SEGMENTS - 1))
          state_d = ST_ON;
      ST_ON:
        if (cfg_q == MODE_OFF) state_d = ST_RETRACT;
      ST_RETRACT:
        if (cfg_q != MODE_OFF)
          state_d = ST_EXTEND;
        // A reversal right at the hilt can enter RETRACT with nothing lit.
        else if (seg_count_q == '0 || (step && seg_count_q == SEG_W'(1)))
          state_d = ST_OFF;
      default:
        state_d = ST_OFF;
    endcase
  end

  // Segment counter and step divider. A direction change only restarts the
  // divider; the segment count carries over so there is no visible jump.
  always_comb begin
    seg_count_d = seg_count_q;
    div_d       = div_q;
    case (state_q)
      ST_EXTEND:
        if (cfg_q != MODE_OFF) begin
          if (step) begin
            seg_count_d = seg_count_q + 1'b1;
            div_d       = '0;
          end else begin
            div_d       = div_q + 1'b1;
          end
        end
      ST_RETRACT:
        if (cfg_q == MODE_OFF && seg_count_q != '0) begin
          if (step) begin
            seg_count_d = seg_count_q - 1'b1;
            div_d       = '0;
          end else begin
            div_d       = div_q + 1'b1;
          end
        end
      default: ;
    endcase
    if (state_d != state_q) div_d = '0;
  end

  always_comb begin
    busy     = (state_q == ST_EXTEND) || (state_q == ST_RETRACT);
    blade_on = (state_q == ST_ON);
    seg_en   = '0;
    for (int i = 0; i < SEGMENTS; i++)
      seg_en[i] = (SEG_W'(i) < seg_count_q);
  end

  // The PWM output register sees the segment count it will be shown with.
  assign lit_d = (seg_count_d != '0);

  blade_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_i    (cfg_q),
    .lit_i     (lit_d),
    .pwm_out_o (pwm_out)
  );

endmodule

// File: tb/tb_lightsaber_blade_driver.sv
module tb_lightsaber_blade_driver;

  logic       clk;
  logic       rst_n;
  logic [1:0] cfg;
  logic [7:0] seg_en;
  logic       pwm_out;
  logic       busy;
  logic       blade_on;

  int n_chk;
  int n_pass;

  logic [3:0] m_cnt;

  lightsaber_blade_driver #(
    .SEGMENTS (8),
    .STEP_DIV (4),
    .PWM_BITS (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (cfg),
    .seg_en   (seg_en),
    .pwm_out  (pwm_out),
    .busy     (busy),
    .blade_on (blade_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference phase of the free-running PWM counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 4'd0;
    else        m_cnt <= m_cnt + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    for (int i = 0; i < 17 && m_cnt != 4'd0; i++) @(negedge clk);
  endtask

  task automatic count_high(output int h);
    h = 0;
    repeat (16) begin
      h += int'(pwm_out);
      @(negedge clk);
    end
  endtask

  int         h;
  int         lvl;
  bit         up;
  logic [7:0] lfsr;
  int         exp_h;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    cfg    = 2'b00;
    wait_neg(3);
    check("rst_seg", seg_en, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_pwm", pwm_out, 1'b0);
    check("rst_on", blade_on, 1'b0);

    // Start extending, then reset in the middle of it.
    rst_n = 1'b1;
    cfg   = 2'b01;
    wait_neg(10);
    check("pre_rst_seg", seg_en, 8'h03);
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_seg", seg_en, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pwm", pwm_out, 1'b0);
    wait_neg(1);
    rst_n = 1'b1;

    // Full extension from 0 with cfg held at 01.
    wait_neg(1);
    check("ext_n_busy", busy, 1'b0);
    wait_neg(1);
    check("ext_n1_busy", busy, 1'b1);
    check("ext_n1_seg", seg_en, 8'h00);
    wait_neg(3);
    check("ext_n4_seg", seg_en, 8'h00);
    wait_neg(1);
    check("ext_n5_seg", seg_en, 8'h01);
    check("ext_n5_pwm", pwm_out, 1'b1);
    wait_neg(27);
    check("ext_n32_seg", seg_en, 8'h7F);
    check("ext_n32_busy", busy, 1'b1);
    wait_neg(1);
    check("ext_n33_seg", seg_en, 8'hFF);
    check("ext_n33_on", blade_on, 1'b1);
    check("ext_n33_busy", busy, 1'b0);
    count_high(h);
    check("solid_high", h, 16);

    // Retract from ON.
    cfg = 2'b00;
    wait_neg(1);
    check("ret_m_on", blade_on, 1'b1);
    wait_neg(1);
    check("ret_m1_busy", busy, 1'b1);
    check("ret_m1_seg", seg_en, 8'hFF);
    wait_neg(3);
    check("ret_m4_seg", seg_en, 8'hFF);
    wait_neg(1);
    check("ret_m5_seg", seg_en, 8'h7F);
    wait_neg(27);
    check("ret_m32_seg", seg_en, 8'h01);
    check("ret_m32_pwm", pwm_out, 1'b1);
    wait_neg(1);
    check("ret_m33_seg", seg_en, 8'h00);
    check("ret_m33_busy", busy, 1'b0);
    check("ret_m33_pwm", pwm_out, 1'b0);
    check("ret_m33_on", blade_on, 1'b0);

    // Reversal mid-extend and back again.
    cfg = 2'b01;
    wait_neg(18);
    check("rev_up_seg", seg_en, 8'h0F);
    cfg = 2'b00;
    wait_neg(2);
    check("rev_dn_busy", busy, 1'b1);
    check("rev_dn_seg0", seg_en, 8'h0F);
    wait_neg(3);
    check("rev_dn_seg3", seg_en, 8'h0F);
    wait_neg(1);
    check("rev_dn_seg4", seg_en, 8'h07);
    cfg = 2'b01;
    wait_neg(2);
    check("rev_up2_seg0", seg_en, 8'h07);
    check("rev_up2_busy", busy, 1'b1);
    wait_neg(3);
    check("rev_up2_seg3", seg_en, 8'h07);
    wait_neg(1);
    check("rev_up2_seg4", seg_en, 8'h0F);
    wait_neg(16);
    check("rev_full_seg", seg_en, 8'hFF);
    check("rev_full_on", blade_on, 1'b1);

    // Pulse mode: high count per period walks the triangle.
    align();
    cfg = 2'b10;
    wait_neg(16);
    lvl = 8;
    up  = 1'b1;
    for (int p = 0; p < 18; p++) begin
      if (up) begin
        if (lvl == 16) begin up = 1'b0; lvl--; end
        else lvl++;
      end else begin
        if (lvl == 8) begin up = 1'b1; lvl++; end
        else lvl--;
      end
      count_high(h);
      check($sformatf("pulse_p%0d", p), h, lvl);
    end
    check("pulse_on", blade_on, 1'b1);
    check("pulse_seg", seg_en, 8'hFF);

    // Unstable mode.
    align();
    cfg = 2'b11;
    wait_neg(16);
    lfsr = 8'hA5;
    for (int p = 0; p < 10; p++) begin
`ifdef BLADE_FLICKER_EN
      lfsr  = {lfsr[6:0], ^(lfsr & 8'hB8)};
      exp_h = 8 + int'(lfsr[2:0]);
`else
      exp_h = 16;
`endif
      count_high(h);
      check($sformatf("unstable_p%0d", p), h, exp_h);
    end
    check("unstable_on", blade_on, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
